// File: rtl/alu_share_arbiter.sv
// Shares one ALU datapath between two requesters with round-robin arbitration,
// a fixed settle latency, per-requester carry flags and a valid/ready response.
// Optional statistics counters are built when ALU_SHARE_STATS_EN is defined.
module alu_share_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req0_branch,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  input  logic             req1_branch,
  output logic [WIDTH-1:0] alu_reg1,
  output logic [WIDTH-1:0] alu_reg2,
  output logic [2:0]       alu_x,
  output logic             alu_branch,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [1:0]       alu_sign,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [1:0]       rsp_sign,
  output logic             rsp_cout,
  output logic             busy
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1,
  output logic [15:0]      conflict_cnt
`endif
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESP} state_t;

  state_t           state, state_nx;
  logic             prio;
  logic [1:0]       carry;
  logic [WIDTH-1:0] lat_a, lat_b;
  logic [2:0]       lat_op;
  logic             lat_branch, lat_id;
  logic [CW-1:0]    cnt;
  logic             cout_new;

  // Carry flag is only rewritten by a plain (non-branch) add.
  assign cout_new = (lat_op == 3'b000 && !lat_branch) ? alu_carry : carry[lat_id];
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and combinational grant; prio breaks ties when both are valid.
  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (req0_valid && (!req1_valid || !prio)) req0_ready = 1'b1;
          else if (req1_valid)                       req1_ready = 1'b1;
          if (req0_valid || req1_valid) state_nx = ISSUE;
        end
      end
      ISSUE:   state_nx = SETTLE;
      SETTLE:  if (cnt == '0) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, ALU bus drive, settle counter, result capture and carries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio       <= 1'b0;
      carry      <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= '0;
      lat_branch <= 1'b0;
      lat_id     <= 1'b0;
      cnt        <= '0;
      alu_reg1   <= '0;
      alu_reg2   <= '0;
      alu_x      <= '0;
      alu_branch <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_sign   <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            lat_a      <= req0_a;
            lat_b      <= req0_b;
            lat_op     <= req0_op;
            lat_branch <= req0_branch;
            lat_id     <= 1'b0;
            prio       <= 1'b1;
          end else if (req1_ready) begin
            lat_a      <= req1_a;
            lat_b      <= req1_b;
            lat_op     <= req1_op;
            lat_branch <= req1_branch;
            lat_id     <= 1'b1;
            prio       <= 1'b0;
          end
        end
        ISSUE: begin
          alu_reg1   <= lat_a;
          alu_reg2   <= lat_b;
          alu_x      <= lat_op;
          alu_branch <= lat_branch;
          cnt        <= CW'(ALU_LAT - 1);
        end
        SETTLE: begin
          if (cnt == '0) begin
            rsp_result    <= alu_result;
            rsp_sign      <= alu_sign;
            rsp_id        <= lat_id;
            rsp_cout      <= cout_new;
            carry[lat_id] <= cout_new;
            rsp_valid     <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ALU_SHARE_STATS_EN
  // Wrapping grant and contention counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (req0_ready) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready) grant_cnt1 <= grant_cnt1 + 16'd1;
      if (state == IDLE && req0_valid && req1_valid) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with an environment ALU that only
// produces correct outputs once its inputs have been stable for LAT cycles.
module tb_alu_share_arbiter;
  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 3;

  typedef struct {logic [W-1:0] a; logic [W-1:0] b; logic [2:0] op; logic br;} op_t;
  typedef struct {logic id; logic [W-1:0] result; logic [1:0] sign; logic cout; int gcyc;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         req0_valid = 0, req0_ready, req0_branch = 0;
  logic [W-1:0] req0_a = 0, req0_b = 0;
  logic [2:0]   req0_op = 0;
  logic         req1_valid = 0, req1_ready, req1_branch = 0;
  logic [W-1:0] req1_a = 0, req1_b = 0;
  logic [2:0]   req1_op = 0;
  logic [W-1:0] alu_reg1, alu_reg2, alu_result;
  logic [2:0]   alu_x;
  logic         alu_branch, alu_carry;
  logic [1:0]   alu_sign;
  logic         rsp_valid, rsp_ready = 0, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_result;
  logic [1:0]   rsp_sign;
`ifdef ALU_SHARE_STATS_EN
  logic [15:0]  grant_cnt0, grant_cnt1, conflict_cnt;
`endif

  alu_share_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) dut (
`ifdef ALU_SHARE_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt),
`endif
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_branch(req0_branch),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_branch(req1_branch),
    .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_x(alu_x), .alu_branch(alu_branch),
    .alu_result(alu_result), .alu_sign(alu_sign), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_sign(rsp_sign), .rsp_cout(rsp_cout), .busy(busy));

  int vectors = 0, miscompares = 0, cyc = 0;
  op_t  q0[$], q1[$];
  exp_t sb[$];
  int   order[$];
  logic [1:0] m_carry = 0;
  logic m_prio = 0;
  int   m_gnt0 = 0, m_gnt1 = 0, m_conf = 0;
  int   rr_mode = 1;
  logic [W-1:0] last_result;
  logic last_cout, prev_rv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W:0] alu_fn(input logic [W-1:0] a, b, input logic [2:0] op, input logic br);
    logic [W:0] sum;
    logic [W-1:0] r;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      3'd0: r = br ? b : sum[W-1:0];
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: r = a;
    endcase
    return {sum[W], r};
  endfunction

  // Environment ALU: outputs are garbage until inputs have held for LAT cycles.
  logic [2*W+3:0] alu_in_c, alu_last = '0;
  int alu_age = 0, alu_age_c;
  logic [W:0] alu_raw;
  assign alu_in_c = {alu_reg1, alu_reg2, alu_x, alu_branch};
  always_comb begin
    alu_age_c = (alu_in_c == alu_last) ? alu_age + 1 : 1;
    alu_raw   = alu_fn(alu_reg1, alu_reg2, alu_x, alu_branch);
    if (alu_age_c >= LAT) begin
      alu_result = alu_raw[W-1:0];
      alu_carry  = alu_raw[W];
      alu_sign   = {alu_reg1 == '0, alu_reg1[W-1]};
    end else begin
      alu_result = ~alu_raw[W-1:0];
      alu_carry  = ~alu_raw[W];
      alu_sign   = ~{alu_reg1 == '0, alu_reg1[W-1]};
    end
  end
  always @(posedge clk) begin
    alu_last <= alu_in_c;
    alu_age  <= alu_age_c;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: results, flags and carries from the arithmetic rules, in grant order.
  task automatic model_accept(input int id, input op_t o, input int gc);
    logic [W:0] r;
    exp_t e;
    r = alu_fn(o.a, o.b, o.op, o.br);
    if (o.op == 3'd0 && !o.br) m_carry[id] = r[W];
    e.id = 1'(id); e.result = r[W-1:0]; e.sign = {o.a == '0, o.a[W-1]};
    e.cout = m_carry[id]; e.gcyc = gc;
    sb.push_back(e);
  endtask

  task automatic drive_req(input int id);
    op_t o;
    logic acc;
    int gc;
    forever begin
      @(negedge clk);
      gc  = cyc;
      acc = !rst && ((id == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready));
      @(posedge clk);
      #1;
      if (acc) begin
        if (id == 0) o = q0.pop_front(); else o = q1.pop_front();
        model_accept(id, o, gc);
      end
      if (rst) begin
        if (id == 0) q0.delete(); else q1.delete();
      end
      if (id == 0) begin
        if (q0.size() > 0) begin
          o = q0[0]; req0_a = o.a; req0_b = o.b; req0_op = o.op; req0_branch = o.br; req0_valid = 1;
        end else req0_valid = 0;
      end else begin
        if (q1.size() > 0) begin
          o = q1[0]; req1_a = o.a; req1_b = o.b; req1_op = o.op; req1_branch = o.br; req1_valid = 1;
        end else req1_valid = 0;
      end
    end
  endtask

  initial drive_req(0);
  initial drive_req(1);

  // Response consumer: 0 random, 1 always ready, 2 stalled.
  always @(posedge clk) begin
    #1;
    rsp_ready = (rr_mode == 0) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
  end

  // Arbitration monitor: round-robin rule and no grants while busy.
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_valid && req1_valid && !busy) m_conf++;
      if (req0_valid || req1_valid) begin
        if (busy) chk("no_grant_busy", {req0_ready, req1_ready}, 2'b00);
        else begin
          chk("grant_when_idle", 64'(req0_ready) + 64'(req1_ready), 1);
          if (req0_valid && req1_valid) chk("rr_winner", req1_ready, m_prio);
          else chk("grant_to_valid", req1_ready, req1_valid);
          if (req0_ready || req1_ready) begin
            m_prio = ~req1_ready;
            if (req1_ready) m_gnt1++; else m_gnt0++;
            order.push_back(req1_ready ? 1 : 0);
          end
        end
      end
    end
  end

  // Response monitor: compares every presented cycle against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: got id %0d result %0h with no outstanding op", rsp_id, rsp_result);
      end else begin
        e = sb[0];
        if (!prev_rv) chk("latency", 64'(cyc - e.gcyc), LAT + 2);
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_result", rsp_result, e.result);
        chk("rsp_sign", rsp_sign, e.sign);
        chk("rsp_cout", rsp_cout, e.cout);
        chk("busy_in_resp", busy, 1);
        if (rsp_ready) begin
          last_result = rsp_result;
          last_cout   = rsp_cout;
          void'(sb.pop_front());
        end
      end
    end
    prev_rv = rsp_valid && !rst;
  end

  task automatic push_op(input int id, input logic [W-1:0] a, b, input logic [2:0] op, input logic br);
    op_t o;
    o.a = a; o.b = b; o.op = op; o.br = br;
    if (id == 0) q0.push_back(o); else q1.push_back(o);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q0.size() || q1.size() || sb.size() || busy) && n < max_cyc);
    if (n >= max_cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d outstanding after %0d cycles, required 0", q0.size() + q1.size() + sb.size(), n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1;
    sb.delete();
    m_carry = 0; m_prio = 0; m_gnt0 = 0; m_gnt1 = 0; m_conf = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [W-1:0] hold_r;
    // Reset values, and no ready while reset is asserted.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu", {alu_reg1, alu_reg2, alu_x, alu_branch}, 0);
    chk("rst_rsp", {rsp_id, rsp_result, rsp_sign, rsp_cout}, 0);
    req0_valid = 1;
    #1;
    chk("rst_ready", req0_ready, 0);
    req0_valid = 0;
`ifdef ALU_SHARE_STATS_EN
    chk("rst_stats", {grant_cnt0, grant_cnt1, conflict_cnt}, 0);
`endif
    @(negedge clk);
    rst = 0;

    // Single add and carry isolation.
    push_op(0, 32'h7FFF_FFFF, 32'h1, 3'd0, 0); wait_drain(50);
    chk("add_result", last_result, 32'h8000_0000);
    chk("add_cout", last_cout, 0);
    push_op(1, 32'hFFFF_FFFF, 32'h1, 3'd0, 0); wait_drain(50);
    chk("carry1_set", last_cout, 1);
    push_op(0, 32'h1, 32'h1, 3'd0, 0); wait_drain(50);
    chk("carry0_isolated", last_cout, 0);
    push_op(1, 32'h5, 32'h3, 3'd2, 0); wait_drain(50);
    chk("carry1_held", last_cout, 1);
    // Branch-mode add: result is operand 2, carry untouched despite raw carry-out.
    push_op(0, 32'hFFFF_FFFF, 32'h40, 3'd0, 1); wait_drain(50);
    chk("branch_result", last_result, 32'h40);
    chk("branch_cout", last_cout, 0);

    // Round robin from reset.
    do_reset();
    order.delete();
    push_op(0, 32'd1, 32'd2, 3'd0, 0); push_op(0, 32'd3, 32'd4, 3'd1, 0);
    push_op(1, 32'd5, 32'd6, 3'd3, 0); push_op(1, 32'd7, 32'd8, 3'd4, 0);
    wait_drain(200);
    chk("rr_count", order.size(), 4);
    if (order.size() == 4) chk("rr_order", {4'(order[0]), 4'(order[1]), 4'(order[2]), 4'(order[3])}, 16'h0101);
`ifdef ALU_SHARE_STATS_EN
    chk("stats_gnt0", grant_cnt0, 2);
    chk("stats_gnt1", grant_cnt1, 2);
    chk("stats_conflict", conflict_cnt, m_conf);
    chk("stats_conflict_nz", conflict_cnt != 0, 1);
`endif

    // Response backpressure with the other requester waiting.
    rr_mode = 2;
    push_op(0, 32'h1234, 32'h0F0F, 3'd2, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
    chk("bp_rsp_valid", rsp_valid, 1);
    push_op(1, 32'h9, 32'h2, 3'd1, 0);
    hold_r = rsp_result;
    repeat (5) begin
      @(negedge clk);
      chk("bp_busy", busy, 1);
      chk("bp_stable", {rsp_valid, rsp_result}, {1'b1, hold_r});
      chk("bp_no_ready", {req0_ready, req1_ready}, 0);
    end
    rr_mode = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(rsp_valid && rsp_ready) && n < 10);
    chk("bp_handshake", rsp_valid && rsp_ready, 1);
    @(negedge clk);
    chk("grant_after_release", req1_ready, 1);
    wait_drain(100);

    // Reset during SETTLE discards the operation and both carries.
    push_op(1, 32'hFFFF_FFFF, 32'h1, 3'd0, 0); wait_drain(50);
    push_op(0, 32'hFFFF_FFFF, 32'h2, 3'd0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!req0_ready && n < 20);
    chk("mid_grant", req0_ready, 1);
    @(posedge clk);
    do_reset();
    repeat (10) @(negedge clk);
    push_op(1, 32'h3, 32'h6, 3'd2, 0); wait_drain(50);
    chk("post_rst_carry1", last_cout, 0);
    chk("post_rst_result", last_result, 32'h2);

    // Randomized traffic with random response backpressure.
    rr_mode = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          if (q0.size() < 3) push_op(0, rnd_operand(), rnd_operand(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0));
        end else begin
          if (q1.size() < 3) push_op(1, rnd_operand(), rnd_operand(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0));
        end
      end
    end
    wait_drain(20000);
`ifdef ALU_SHARE_STATS_EN
    chk("stats_rand_gnt0", grant_cnt0, 16'(m_gnt0));
    chk("stats_rand_gnt1", grant_cnt1, 16'(m_gnt1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no completion, required finish");
    $fatal(1);
  end
endmodule
